ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter CLK_DIV, default 2500, sets the PS/2 clock half-period in clk cycles (range 2..65535).
REQ-002 Parameter GAP_BITS, default 2, sets the idle bit-periods inserted after each frame (range 1..15).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 din  input  8  byte (scan code) to transmit.
REQ-006 valid  input  1  din is valid; a transfer occurs on a rising clk edge with valid && ready.
REQ-007 ready  output  1  block can accept a byte this cycle.
REQ-008 ps2_clk  output  1  PS/2 device clock; idle high.
REQ-009 ps2_data  output  1  PS/2 device data; idle high.
REQ-010 busy  output  1  high from the first cycle of a frame through the last cycle of its gap.

Function
REQ-011 The block SHALL act as the device (keyboard) end of a PS/2 link, driving frames a host receiver samples on ps2_clk falling edges.
REQ-012 Frame SHALL be 11 bits in order: start 0, din[0]..din[7] (LSB first), odd parity (bit = ~^din), stop 1.
REQ-013 Each bit period SHALL be 2*CLK_DIV cycles: ps2_data set at period start, ps2_clk high for the first CLK_DIV cycles, low for the next CLK_DIV cycles.
REQ-014 ps2_data SHALL change only while ps2_clk is high, never on the same cycle ps2_clk falls.
REQ-015 After the stop bit, the block SHALL hold ps2_clk=1, ps2_data=1 for GAP_BITS*2*CLK_DIV cycles before starting another frame.
REQ-016 State machine: IDLE -> SEND (11 bit-periods, bit index 0..10) -> GAP -> IDLE; IDLE -> SEND when a byte is available.
REQ-017 From IDLE, a byte accepted at edge t SHALL put the start bit on ps2_data (=0) and raise busy in the cycle after edge t.
REQ-018 Total frame + gap duration SHALL be exactly (11+GAP_BITS)*2*CLK_DIV cycles; busy SHALL fall in the cycle after the gap ends.
REQ-019 A byte whose frame has started SHALL be transmitted completely; din/valid changes mid-frame SHALL have no effect on it.
REQ-020 Outputs SHALL be registered (no combinational path from din/valid to ps2_clk/ps2_data).

Reset
REQ-021 While rst=0: ps2_clk=1, ps2_data=1, busy=0, ready=0, state IDLE, counters and buffer cleared, immediately (asynchronously).
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release, no partial frame is resumed and ready rises on the first clk edge.

Configuration
REQ-023 Macro PS2_TX_FIFO_EN SHALL select buffering.
REQ-024 With PS2_TX_FIFO_EN defined: 4-entry FIFO; ready = FIFO not full; frames start from IDLE whenever FIFO is non-empty, oldest first; push while full is not accepted even if a pop occurs the same cycle; push and pop in one cycle when not full both occur.
REQ-025 Without PS2_TX_FIFO_EN: no buffer; ready=1 only in IDLE and when not in reset; valid outside IDLE is ignored.

Verification (CLK_DIV=4, GAP_BITS=1)
REQ-026 Send 0x1C from idle -> ps2_data on successive falling ps2_clk edges reads 0,0,0,1,1,1,0,0,0,0,1 (parity 0); busy high for exactly 96 cycles.
REQ-027 Send 0xF0, 0x00, 0xFF -> parity bits 1,1,1 respectively; stop bit 1 in each; ps2_data never toggles while ps2_clk is low.
REQ-028 With FIFO: push 0x12,0x34,0x56,0x78 on back-to-back cycles -> all accepted, ready low after 4th push, four frames emitted in order, each separated by 8 idle-high cycles.
REQ-029 Without FIFO: valid held with 0xAA during an active frame -> not accepted until IDLE; exactly one 0xAA frame follows.
REQ-030 Assert rst at cycle 30 of a frame -> ps2_clk=1, ps2_data=1, busy=0 same cycle; after release and new byte 0x5A, complete correct frame with no remnant of the aborted one.

Source files
------------

// File: rtl/ps2_tx.sv
// ps2_tx: device (keyboard) end of a PS/2 link. Serialises one byte per frame
// (start, 8 data bits LSB first, odd parity, stop) on ps2_clk/ps2_data, then
// holds the line idle for GAP_BITS bit-periods before the next frame.
// Define PS2_TX_FIFO_EN to add a 4-entry input FIFO; without it the block
// accepts a byte only while idle.
module ps2_tx #(
    parameter int CLK_DIV  = 2500,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       valid,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int              PERIOD    = 2 * CLK_DIV;
    localparam int              CW        = $clog2(PERIOD);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   PER_LAST  = CW'(PERIOD - 1);
    localparam logic [3:0]      STOP_IDX  = 4'd10;
    localparam logic [3:0]      GAP_LAST  = 4'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;       // cycle within the current bit-period
    logic [3:0]      bit_q, bit_d;       // frame bit index, or gap bit index
    logic [9:0]      shift_q, shift_d;   // bits still to send after the current one
    logic            clk_q, clk_d;
    logic            data_q, data_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    logic            have_byte;          // a byte is available to start a frame
    logic [7:0]      next_byte;          // the byte a new frame would carry

`ifdef PS2_TX_FIFO_EN
    logic [7:0]      mem_q [4];
    logic [1:0]      wr_q, rd_q;
    logic [2:0]      count_q, count_d;
    logic            push;
    logic            pop;

    // The head entry stays in the FIFO until its gap ends, so the byte in
    // flight still occupies a slot.
    assign push      = valid && ready_q;
    assign pop       = (state_q == S_GAP) && (cnt_q == PER_LAST) && (bit_q == GAP_LAST);
    assign have_byte = (count_q != 3'd0);
    assign next_byte = mem_q[rd_q];

    // Occupancy after this cycle's push/pop; ready only follows from the old full flag.
    always_comb begin
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        ready_d = (count_d != 3'd4);
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage is cleared on reset so no stale byte survives an abort;
            // this is deliberate, most RAM-style arrays should be left unreset.
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            count_q <= count_d;
        end
    end
`else
    assign have_byte = valid && ready_q;
    assign next_byte = din;

    // Unbuffered: accept only while the next cycle is idle.
    always_comb ready_d = (state_d == S_IDLE);
`endif

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned
        // (which would infer a latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        clk_d   = clk_q;
        data_d  = data_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                busy_d = 1'b0;
                if (have_byte) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = {1'b1, ~^next_byte, next_byte};
                    data_d  = 1'b0;            // start bit
                    busy_d  = 1'b1;
                end
            end

            S_SEND: begin
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (bit_q == STOP_IDX) begin
                        state_d = S_GAP;
                        bit_d   = '0;
                        data_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        data_d  = shift_q[0];
                        shift_d = {1'b1, shift_q[9:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == HALF_LAST) clk_d = 1'b0;
                end
            end

            S_GAP: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (bit_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset forces the idle line immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx (CLK_DIV=4, GAP_BITS=1). Stimulus
// pushes the expected 11-bit frame into a queue; a monitor decodes frames from
// ps2_clk falling edges and compares them, and also checks line rules, gap
// length and busy duration.
module tb_ps2_tx;

    localparam int CLK_DIV   = 4;
    localparam int GAP_BITS  = 1;
    localparam int FRAME_CYC = (11 + GAP_BITS) * 2 * CLK_DIV;   // 96
    localparam int GAP_CYC   = GAP_BITS * 2 * CLK_DIV;          // 8

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .valid    (valid),
        .ready    (ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: bit i is what the host reads on the i-th falling edge.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Monitor: decodes frames and checks line timing, sampling on negedge clk.
    initial begin
        logic        prev_clk  = 1'b1;
        logic        prev_data = 1'b1;
        logic [10:0] rx = '0;
        logic [10:0] exp;
        int          nbits = 0;
        bit          viol = 1'b0;
        bit          seen_frame = 1'b0;
        int          hi_run = 0;
        int          busy_run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                nbits = 0; viol = 1'b0; seen_frame = 1'b0;
                hi_run = 0; busy_run = 0;
                prev_clk = 1'b1; prev_data = 1'b1;
            end else begin
                if (!ps2_clk && ps2_data !== prev_data) viol = 1'b1;
                // Start bit appearing: idle-high stretch since the last frame must cover the gap.
                if (ps2_clk && !ps2_data && prev_data && nbits == 0 && seen_frame)
                    check("gap_idle_high", (hi_run >= GAP_CYC) ? 32'd1 : 32'd0, 32'd1);
                if (ps2_clk && ps2_data) hi_run++;
                else                     hi_run = 0;
                if (prev_clk && !ps2_clk) begin
                    rx[nbits] = ps2_data;
                    nbits++;
                    if (nbits == 11) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_unexpected actual=0x%0h expected=none", rx);
                        end else begin
                            exp = exp_q.pop_front();
                            check("frame_bits", rx, exp);
                        end
                        check("data_stable_clk_low", viol, 1'b0);
                        viol = 1'b0;
                        nbits = 0;
                        seen_frame = 1'b1;
                    end
                end
                if (busy) busy_run++;
                else if (busy_run > 0) begin
                    check("busy_length", busy_run, FRAME_CYC);
                    busy_run = 0;
                end
                prev_clk  = ps2_clk;
                prev_data = ps2_data;
            end
        end
    end

    // Offer one byte, hold valid until accepted, then scramble din.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        din   = b;
        valid = 1'b1;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_low expected=accept byte=0x%0h", b);
            valid = 1'b0;
            return;
        end
        exp_q.push_back(model_frame(b));
        @(posedge clk);
        #1;
`ifndef PS2_TX_FIFO_EN
        check("start_bit_latency", ps2_data, 1'b0);
        check("busy_latency", busy, 1'b1);
        check("ready_low_in_frame", ready, 1'b0);
`endif
        @(negedge clk);
        valid = 1'b0;
        din   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=pending=%0d expected=pending=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
`ifdef PS2_TX_FIFO_EN
        logic [7:0] vals [4];
        vals[0] = 8'h12; vals[1] = 8'h34; vals[2] = 8'h56; vals[3] = 8'h78;
`endif
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ps2_clk", ps2_clk, 1'b1);
        check("rst_ps2_data", ps2_data, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", ready, 1'b1);

        // Known scan codes, including parity corner cases.
        send(8'h1C);
        wait_idle();
        send(8'hF0);
        send(8'h00);
        send(8'hFF);
        wait_idle();

`ifdef PS2_TX_FIFO_EN
        // Four back-to-back pushes fill the FIFO; a fifth offer is refused.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din   = vals[i];
            valid = 1'b1;
            check("fifo_ready_push", ready, 1'b1);
            exp_q.push_back(model_frame(vals[i]));
        end
        @(posedge clk);
        #1;
        check("fifo_full_ready", ready, 1'b0);
        @(negedge clk);
        din = 8'h99;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        wait_idle();
`else
        // 0xAA offered during an active frame: taken once, after the frame.
        send(8'h11);
        send(8'hAA);
        wait_idle();
`endif

        // Randomised bytes with random spacing.
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send(b);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();

        // Reset in cycle 30 of a frame, then a clean frame afterwards.
        send(8'h3C);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ps2_clk", ps2_clk, 1'b1);
        check("abort_ps2_data", ps2_data, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", ready, 1'b1);
        send(8'h5A);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
